// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
// The master side (decoder/datapath) issues operations; the slave side is the unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i,
        output op_i,
        output src1_i,
        output src2_i,
        input  busy_o,
        input  done_o,
        input  hi_o,
        input  lo_o
    );

    modport slave (
        input  start_i,
        input  op_i,
        input  src1_i,
        input  src2_i,
        output busy_o,
        output done_o,
        output hi_o,
        output lo_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Magnitudes are processed unsigned for 32 iterations (shift-add multiply or
// restoring divide); signs are re-applied in a single FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mult_div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     count_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    // Captured operation context
    logic                 is_div_q;
    logic                 neg_res_q;   // product / quotient must be negated
    logic                 neg_rem_q;   // remainder must be negated (dividend < 0)
    logic                 div_zero_q;
    logic [WIDTH-1:0]     src1_orig_q; // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]     operand_q;   // multiplicand (mult) or divisor (div) magnitude
    // Working register: mult = {partial upper, multiplier bits},
    //                   div  = {remainder, dividend/quotient bits}
    logic [2*WIDTH-1:0]   prod_q;

    // Capture-side decode of the incoming request
    logic                 cap_signed;
    logic                 cap_div;
    logic [WIDTH-1:0]     cap_mag_a;
    logic [WIDTH-1:0]     cap_mag_b;

    // One iteration of each algorithm
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_step;

    // Sign-fixed results written at the end of FIX
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     hi_fix;
    logic [WIDTH-1:0]     lo_fix;

    // Decode the request and form operand magnitudes (signed ops only)
    always_comb begin
        cap_signed = bus.op_i[0];
        cap_div    = bus.op_i[1];
        cap_mag_a  = bus.src1_i;
        cap_mag_b  = bus.src2_i;
        if (cap_signed && bus.src1_i[WIDTH-1]) begin
            cap_mag_a = -bus.src1_i;
        end
        if (cap_signed && bus.src2_i[WIDTH-1]) begin
            cap_mag_b = -bus.src2_i;
        end
    end

    // Single iteration datapaths for shift-add multiply and restoring divide
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, prod_q[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder, then trial-subtract
        div_shift = prod_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, operand_q};
        if (div_diff[WIDTH]) begin
            div_step = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end
    end

    // Apply result signs and the divide-by-zero convention
    always_comb begin
        prod_neg = -prod_q;
        quot_fix = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            hi_fix = neg_res_q ? prod_neg[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
            lo_fix = neg_res_q ? prod_neg[WIDTH-1:0]       : prod_q[WIDTH-1:0];
        end else if (div_zero_q) begin
            hi_fix = src1_orig_q;
            lo_fix = {WIDTH{1'b1}};
        end else begin
            hi_fix = rem_fix;
            lo_fix = quot_fix;
        end
    end

    // Control FSM with registered busy/done and HI/LO result registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            src1_orig_q <= '0;
            operand_q   <= '0;
            prod_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        state_q     <= CALC;
                        busy_q      <= 1'b1;
                        count_q     <= '0;
                        is_div_q    <= cap_div;
                        neg_res_q   <= cap_signed
                                       && (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
                        neg_rem_q   <= cap_signed && bus.src1_i[WIDTH-1];
                        div_zero_q  <= cap_div && (bus.src2_i == '0);
                        src1_orig_q <= bus.src1_i;
                        if (cap_div) begin
                            operand_q <= cap_mag_b;
                            prod_q    <= {{WIDTH{1'b0}}, cap_mag_a};
                        end else begin
                            operand_q <= cap_mag_a;
                            prod_q    <= {{WIDTH{1'b0}}, cap_mag_b};
                        end
                    end
                end
                CALC: begin
                    prod_q  <= is_div_q ? div_step : mul_step;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_ITER) begin
                        state_q <= FIX;
                        count_q <= '0;
                    end
                end
                FIX: begin
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Table-driven bench for mult_div_unit with a result scoreboard, plus
// hand-written handshake-robustness and mid-operation reset sequences.
module tb_mult_div_unit;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   done_count;
    exp_t sb_q[$];
    vec_t vecs[12];

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) begin
            exp_t e;
            done_count++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: actual=done pulse expected=none hi=%h lo=%h",
                         bus.hi_o, bus.lo_o);
            end else begin
                e = sb_q.pop_front();
                $display("done: hi=%h lo=%h (expected hi=%h lo=%h)",
                         bus.hi_o, bus.lo_o, e.hi, e.lo);
                check("sb_hi", bus.hi_o, e.hi);
                check("sb_lo", bus.lo_o, e.lo);
            end
        end
    end

    // Issue one operation, push its expected result, and check timing
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        sb_q.push_back('{hi: ehi, lo: elo});
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check({name, "_busy_start"}, 32'(bus.busy_o), 32'd1);
        cyc = 0;
        while (bus.done_o !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'd33);
        @(posedge clk);
        #1;
        check({name, "_done_low"}, 32'(bus.done_o), 32'd0);
        check({name, "_busy_low"}, 32'(bus.busy_o), 32'd0);
        $display("op %s: op=%b a=%h b=%h -> hi=%h lo=%h", name, op, a, b, bus.hi_o, bus.lo_o);
    endtask

    initial begin
        int   cyc;
        int   done_before;

        n_checks    = 0;
        n_fail      = 0;
        done_count  = 0;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.src1_i  = '0;
        bus.src2_i  = '0;

        vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x7",   OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"mult_min2",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{"divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{"div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{"div_7_m2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[6]  = '{"divu_5_0",    OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[7]  = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{"div_m5_0",    OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{"mult_5_m1",   OP_MULT,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[10] = '{"divu_max_1",  OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{"div_m100_m7", OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_hi",   bus.hi_o, 32'd0);
        check("rst_lo",   bus.lo_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // Handshake robustness: inputs and start change while busy
        done_before = done_count;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = OP_MULTU;
        bus.src1_i  = 32'd3;
        bus.src2_i  = 32'd4;
        sb_q.push_back('{hi: 32'd0, lo: 32'd12});
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIV;
        bus.src1_i  = 32'd99;
        bus.src2_i  = 32'd77;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        cyc = 6;
        while (bus.done_o !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hs_latency", 32'(cyc), 32'd33);
        // Raise start during the DONE cycle: must be ignored
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check("hs_busy_after_done", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        check("hs_no_restart", 32'(bus.busy_o), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("hs_hold_hi", bus.hi_o, 32'd0);
        check("hs_hold_lo", bus.lo_o, 32'd12);
        check("hs_single_done", 32'(done_count - done_before), 32'd1);
        $display("op handshake: multu 3x4 with busy-time changes -> hi=%h lo=%h",
                 bus.hi_o, bus.lo_o);

        // Reset in the middle of a DIV: aborted, no done, results cleared
        done_before = done_count;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIV;
        bus.src1_i  = 32'd1000;
        bus.src2_i  = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_busy", 32'(bus.busy_o), 32'd0);
        check("rstmid_done", 32'(bus.done_o), 32'd0);
        check("rstmid_hi",   bus.hi_o, 32'd0);
        check("rstmid_lo",   bus.lo_o, 32'd0);
        rst_n = 1'b1;
        $display("op reset_mid_div: aborted at cycle 10 -> hi=%h lo=%h", bus.hi_o, bus.lo_o);
        run_op("after_rst_divu", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);
        check("rstmid_done_count", 32'(done_count - done_before), 32'd1);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
